// File: rtl/pulse_width_meter.sv
// Multi-channel pulse-width meter: per-channel synchroniser, width-counting FSM and
// one-deep holding register, merged onto a single valid/ready port by round-robin.
module pulse_width_meter #(
  parameter  int CHANNELS    = 4,
  parameter  int CNT_W       = 16,
  parameter  int SYNC_STAGES = 2,
  parameter  int MIN_WIDTH   = 1,
  parameter  int ACTIVE_HIGH = 1,
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                sys_clk,
  input  logic                a_reset,
  input  logic [CHANNELS-1:0] pulse,
  input  logic [CHANNELS-1:0] ch_en,
  input  logic                res_ready,
  output logic                res_valid,
  output logic [CNT_W-1:0]    res_data,
  output logic [CH_W-1:0]     res_ch,
  output logic                res_ovf,
  output logic                res_lost
);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT    = '1;
  localparam logic [CNT_W-1:0] MIN_CNT    = CNT_W'(MIN_WIDTH);
  localparam logic             INACTIVE   = (ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;
  localparam logic             SAT_AT_ONE = (CNT_W == 1);

  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] lost;
  logic [CHANNELS-1:0] hold_ovf;
  logic [CHANNELS-1:0] grant;
  logic [CNT_W-1:0]    hold_data [CHANNELS];

  logic            load_out;
  logic            found;
  logic [CH_W-1:0] ptr;
  logic [CH_W-1:0] sel;
  logic [CH_W-1:0] idx;

  assign load_out = !res_valid || res_ready;

  // Search starts one past the last granted channel and wraps once around.
  always_comb begin
    found = 1'b0;
    sel   = ptr;
    idx   = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      idx = CH_W'((int'(ptr) + k) % CHANNELS);
      if (!found && pending[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic                   ovf;
    logic                   active;
    logic                   offer;
    logic [CNT_W-1:0]       data_q;
    logic                   ovf_q;
    logic                   pend_q;
    logic                   lost_q;

    assign active   = (sync[SYNC_STAGES-1] != INACTIVE);
    assign offer    = ch_en[gi] && (state == DONE) && (cnt >= MIN_CNT);
    assign grant[gi] = load_out && found && (sel == CH_W'(gi));

    always_ff @(posedge sys_clk or posedge a_reset) begin
      if (a_reset) begin
        sync  <= {SYNC_STAGES{INACTIVE}};
        state <= IDLE;
        cnt   <= '0;
        ovf   <= 1'b0;
      end else begin
        sync <= {sync[SYNC_STAGES-2:0], pulse[gi]};
        if (!ch_en[gi]) begin
          state <= IDLE;
          cnt   <= '0;
          ovf   <= 1'b0;
        end else begin
          case (state)
            IDLE: if (active) begin
              state <= COUNT;
              cnt   <= CNT_W'(1);
              ovf   <= SAT_AT_ONE;
            end
            COUNT: if (active) begin
              if (cnt != MAX_CNT) begin
                cnt <= cnt + 1'b1;
                if (cnt == MAX_CNT - 1'b1) ovf <= 1'b1;
              end
            end else begin
              state <= DONE;
            end
            default: if (active) begin
              // A single inactive cycle is enough to separate two pulses.
              state <= COUNT;
              cnt   <= CNT_W'(1);
              ovf   <= SAT_AT_ONE;
            end else begin
              state <= IDLE;
              cnt   <= '0;
              ovf   <= 1'b0;
            end
          endcase
        end
      end
    end

    always_ff @(posedge sys_clk or posedge a_reset) begin
      if (a_reset) begin
        data_q <= '0;
        ovf_q  <= 1'b0;
        pend_q <= 1'b0;
        lost_q <= 1'b0;
      end else begin
        if (grant[gi]) begin
          pend_q <= 1'b0;
          lost_q <= 1'b0;
        end
        if (offer) begin
          if (!pend_q || grant[gi]) begin
            data_q <= cnt;
            ovf_q  <= ovf;
            pend_q <= 1'b1;
          end else begin
            lost_q <= 1'b1;
          end
        end
      end
    end

    assign pending[gi]   = pend_q;
    assign lost[gi]      = lost_q;
    assign hold_ovf[gi]  = ovf_q;
    assign hold_data[gi] = data_q;
  end

  always_ff @(posedge sys_clk or posedge a_reset) begin
    if (a_reset) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_ch    <= '0;
      res_ovf   <= 1'b0;
      res_lost  <= 1'b0;
      ptr       <= CH_W'(CHANNELS - 1);
    end else if (load_out) begin
      if (found) begin
        res_valid <= 1'b1;
        res_data  <= hold_data[sel];
        res_ch    <= sel;
        res_ovf   <= hold_ovf[sel];
        res_lost  <= lost[sel];
        ptr       <= sel;
      end else begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/pulse_width_meter.md
# pulse_width_meter

Multi-channel pulse-width measurement engine, the parametrised successor to the single-channel pulse counter control FSM. Each channel synchronises its PULSE input, counts SYS_CLK cycles while the pulse is active, and captures the completed width with saturation and minimum-width glitch rejection. Completed measurements from all channels are merged onto one valid/ready result port through a round-robin arbiter. The block sits between the raw pulse inputs and the measurement readout logic.

## Interface
- CHANNELS, 4, number of independent pulse inputs (1..16)
- CNT_W, 16, width counter and result width in bits
- SYNC_STAGES, 2, flops in each PULSE input synchroniser (>=2)
- MIN_WIDTH, 1, smallest count that produces a result; shorter pulses are discarded (1..2^CNT_W-1)
- ACTIVE_HIGH, 1, 1: measure high time; 0: measure low time
- SYS_CLK  in  1  system clock, all logic on rising edge
- A_RESET  in  1  asynchronous, active-high reset
- PULSE  in  CHANNELS  raw asynchronous pulse inputs
- CH_EN  in  CHANNELS  per-channel enable, synchronous
- RES_READY  in  1  consumer accepts result
- RES_VALID  out  1  result register holds a measurement
- RES_DATA  out  CNT_W  measured width in SYS_CLK cycles
- RES_CH  out  clog2(CHANNELS), min 1  channel index of result
- RES_OVF  out  1  width saturated at 2^CNT_W-1
- RES_LOST  out  1  at least one earlier result of this channel was dropped since its last transfer

## Operation
- Active level: sync output equals ACTIVE_HIGH.
- Per-channel FSM, states IDLE, COUNT, DONE:
  - IDLE: cnt=0. Active → COUNT with cnt=1.
  - COUNT: active → cnt+1, saturating at 2^CNT_W-1 (sets ovf, sticky for this pulse); inactive → DONE.
  - DONE: offer {cnt, ovf} to holding register if cnt >= MIN_WIDTH, else discard silently. Active → COUNT with cnt=1, ovf=0 (back-to-back pulse not lost); inactive → IDLE.
- CH_EN=0: FSM forced to IDLE, cnt/ovf cleared, in-progress pulse aborted with no result; holding register and lost flag untouched. Re-enable mid-pulse: the partial pulse is counted from the first enabled active cycle.
- Holding register per channel (one entry + pending bit + sticky lost bit):
  - Offer while not pending, or while pending and being moved to output the same cycle → load, pending=1.
  - Offer while pending and not moved → new result dropped, lost=1, old kept.
- Output stage: single register. When RES_VALID=0, or RES_VALID&RES_READY, load from the next pending channel in round-robin order starting after the last granted channel; clear that channel's pending and lost bits; RES_LOST carries the lost bit as it was before clearing. No pending channel → RES_VALID=0.
- Handshake: transfer on RES_VALID&RES_READY at rising edge. RES_DATA/RES_CH/RES_OVF/RES_LOST stable while RES_VALID=1 and RES_READY=0. RES_VALID does not depend combinationally on RES_READY.

## Timing
- Reset: all FSMs IDLE, cnt/ovf/pending/lost=0, synchronisers 0 (ACTIVE_HIGH=0: reset value 1 so no false pulse), round-robin pointer at channel CHANNELS-1 (channel 0 first), RES_VALID=0, RES_DATA/RES_CH/RES_OVF/RES_LOST=0.
- Reset mid-operation discards every in-flight count, pending result and output word.
- Input latency: raw PULSE change sampled at edge E0 reaches the FSM decision at edge E0+SYNC_STAGES.
- Pulse of N synchronised active cycles → RES_DATA=N (or 2^CNT_W-1 with RES_OVF=1 if N >= 2^CNT_W-1).
- FSM sees inactive at edge E → DONE; holding loaded at E+1; RES_VALID=1 after E+2 if output free. Raw falling edge to RES_VALID: SYNC_STAGES+2 cycles.
- Sustained throughput: one result per cycle with RES_READY held high.
- Minimum measurable gap: one inactive cycle (the DONE cycle).

## Test plan
- Single pulse: CHANNELS=4, ch0 high 10 cycles, RES_READY=1 → one transfer RES_CH=0, RES_DATA=10, RES_OVF=0, RES_LOST=0, RES_VALID rises SYNC_STAGES+2 cycles after fall.
- Saturation: CNT_W=4, pulse 20 cycles → RES_DATA=15, RES_OVF=1; next 3-cycle pulse → RES_DATA=3, RES_OVF=0.
- Glitch reject / back-to-back: MIN_WIDTH=3, pulses 2, gap 1, 5 cycles → only RES_DATA=5 emitted.
- Arbitration: ch0..ch3 end simultaneously with widths 4,5,6,7, RES_READY=1 → transfers in order ch0,ch1,ch2,ch3 on consecutive cycles; repeat after granting ch1 → order ch2,ch3,ch0,ch1.
- Backpressure/lost: RES_READY=0, ch2 pulses 4, 6, 8 → output holds 4, holding holds 6, 8 dropped; raise RES_READY → 4 (LOST=0), then 6 with RES_LOST=1; output stable while stalled.
- Disable/reset: CH_EN[1] dropped mid-pulse → no result; A_RESET pulsed with RES_VALID=1 → all outputs 0 asynchronously, no later emission.
